// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, diff = a - b, LSB first
// One registered full-subtractor cell, start/done handshake, WIDTH clocks per result.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_res;
   logic             r_bin;
   logic [CNT_W-1:0] r_cnt;

   logic             w_x;
   logic             w_y;
   logic             w_d;
   logic             w_bout;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   assign w_x        = r_op_a[0];
   assign w_y        = r_op_b[0];
   assign w_d        = w_x ^ w_y ^ r_bin;
   assign w_bout     = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);
   assign w_last     = (r_cnt == LAST_STEP);
   // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_res   <= '0;
         r_bin   <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op_a  <= a;
                  r_op_b  <= b;
                  r_res   <= '0;
                  r_bin   <= 1'b0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_op_a <= r_op_a >> 1;
               r_op_b <= r_op_b >> 1;
               r_res  <= w_res_next;
               r_bin  <= w_bout;
               r_cnt  <= r_cnt + 1'b1;
               // Outputs are published only here, so a reset mid-run leaves them cleared.
               if (w_last) begin
                  diff    <= w_res_next;
                  borrow  <= w_bout;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor, WIDTH = 8 and 3
module tb_serial_subtractor;

   typedef struct {
      int         cyc;
      logic [8:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, borrow8;
   logic [7:0] diff8;

   logic       start3 = 1'b0;
   logic [2:0] a3 = '0, b3 = '0;
   logic       busy3, done3, borrow3;
   logic [2:0] diff3;

   exp_t q8[$];
   exp_t q3[$];
   int   checks = 0;
   int   errors = 0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_subtractor #(.WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Plain-arithmetic reference: {borrow, diff} with diff in the low bits.
   function automatic logic [8:0] ref_sub(input int w, input int av, input int bv);
      int m = 1 << w;
      int d = (av - bv + m) % m;
      logic [8:0] r;
      r    = 9'(d);
      r[8] = (av < bv);
      return r;
   endfunction

   // Monitors: pop and compare on every done; results must hold between completions.
   logic [8:0] prev8 = '0, prev3 = '0;
   int         run8 = 0, run3 = 0;
   exp_t       e8, e3;

   always @(negedge clk) begin
      if (rst_n) begin
         if (done8) begin
            if (q8.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut8_unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               e8 = q8.pop_front();
               chk("dut8_done_cycle", cyc, e8.cyc);
               chk("dut8_result", {borrow8, diff8}, e8.val);
               chk("dut8_busy_len", run8, 8);
            end
         end else begin
            chk("dut8_result_hold", {borrow8, diff8}, prev8);
         end
      end
      prev8 = {borrow8, diff8};
      run8  = busy8 ? run8 + 1 : 0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done3) begin
            if (q3.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut3_unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               e3 = q3.pop_front();
               chk("dut3_done_cycle", cyc, e3.cyc);
               chk("dut3_result", {borrow3, 5'b0, diff3}, e3.val);
               chk("dut3_busy_len", run3, 3);
            end
         end else begin
            chk("dut3_result_hold", {borrow3, 5'b0, diff3}, prev3);
         end
      end
      prev3 = {borrow3, 5'b0, diff3};
      run3  = busy3 ? run3 + 1 : 0;
   end

   // Drivers are called at posedge+2; the start is accepted on the next edge.
   task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
      int g = 0;
      while (busy8 && g < 100) begin @(posedge clk); #2; g++; end
      if (g >= 100) begin
         checks++; errors++;
         $display("FAIL dut8_busy_timeout: got busy=1 expected idle within 100 cycles");
      end
      a8 = av; b8 = bv; start8 = 1'b1;
      q8.push_back('{cyc + 1 + 8, ref_sub(8, int'(av), int'(bv))});
      @(posedge clk); #2;
      start8 = 1'b0;
   endtask

   task automatic issue3(input logic [2:0] av, input logic [2:0] bv);
      int g = 0;
      while (busy3 && g < 100) begin @(posedge clk); #2; g++; end
      if (g >= 100) begin
         checks++; errors++;
         $display("FAIL dut3_busy_timeout: got busy=1 expected idle within 100 cycles");
      end
      a3 = av; b3 = bv; start3 = 1'b1;
      q3.push_back('{cyc + 1 + 3, ref_sub(3, int'(av), int'(bv))});
      @(posedge clk); #2;
      start3 = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((q8.size() != 0 || q3.size() != 0) && g < 200) begin @(posedge clk); #2; g++; end
      if (g >= 200) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q8.size(), q3.size());
      end
      @(posedge clk); #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("reset_busy8", busy8, 0);
      chk("reset_done8", done8, 0);
      chk("reset_out8", {borrow8, diff8}, 0);
      chk("reset_out3", {busy3, done3, borrow3, diff3}, 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      issue8(8'h5A, 8'h23);
      drain();
      issue8(8'h10, 8'h20);
      issue8(8'h00, 8'h01);
      issue8(8'hA5, 8'hA5);
      issue8(8'hFF, 8'h00);
      drain();

      // start while busy must be ignored; operands toggle every cycle
      issue8(8'h80, 8'h01);
      for (int i = 0; i < 12; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         start8 = (i == 1);
         if (i == 1) begin a8 = 8'h00; b8 = 8'hFF; end
         @(posedge clk); #2;
      end
      start8 = 1'b0;
      drain();
      chk("ignored_start_idle", busy8, 0);

      // async reset mid-operation
      issue8(8'h12, 8'h34);
      repeat (2) begin @(posedge clk); #2; end
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", busy8, 0);
      chk("midreset_done", done8, 0);
      chk("midreset_out", {borrow8, diff8}, 0);
      q8.delete();
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #2; end
      chk("post_reset_idle", busy8, 0);
      issue8(8'h03, 8'h05);
      drain();

      // back-to-back: second start lands in the done cycle of the first
      issue8(8'h01, 8'h02);
      issue8(8'h40, 8'h30);
      issue8(8'h33, 8'hC4);
      drain();

      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
               issue8(8'($urandom), 8'($urandom));
            end
         end
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
               issue3(3'($urandom), 3'($urandom));
            end
         end
      join
      drain();
      repeat (12) begin @(posedge clk); #2; end
      chk("final_q8_empty", q8.size(), 0);
      chk("final_q3_empty", q3.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
